// File: rtl/prt_dp_pm_lb_arb_pkg.sv
// rtl/prt_dp_pm_lb_arb_pkg.sv - shared types and constants for the PM local-bus arbiter
package prt_dp_pm_lb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RWAIT,
        ST_RESP
    } lb_state_t;

    // Word returned to a master whose read timed out
    localparam logic [31:0] ERR_DATA = 32'hdeadcafe;

endpackage

// File: rtl/prt_dp_lib_rr_arb.sv
// rtl/prt_dp_lib_rr_arb.sv - combinational round-robin grant, first requester after ptr wins
module prt_dp_lib_rr_arb #(
    parameter int P_REQ   = 2,
    parameter int P_IDX_W = (P_REQ > 1) ? $clog2(P_REQ) : 1
) (
    input  logic [P_REQ-1:0]   req,
    input  logic [P_IDX_W-1:0] ptr,
    output logic [P_REQ-1:0]   gnt,
    output logic [P_IDX_W-1:0] gnt_idx,
    output logic               any
);

    // Scan requesters starting one past the pointer, wrapping modulo P_REQ
    always_comb begin
        int k;
        k       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 1; i <= P_REQ; i++) begin
            k = (int'(ptr) + i) % P_REQ;
            if (!any && req[P_IDX_W'(k)]) begin
                any     = 1'b1;
                gnt_idx = P_IDX_W'(k);
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/prt_dp_pm_lb_arb.sv
// rtl/prt_dp_pm_lb_arb.sv - round-robin local-bus arbiter with single-strobe reads and read timeout
module prt_dp_pm_lb_arb
    import prt_dp_pm_lb_arb_pkg::*;
#(
    parameter int P_REQ       = 2,
    parameter int P_ADR_WIDTH = 4,
    parameter int P_DAT_WIDTH = 32,
    parameter int P_TIMEOUT   = 15
) (
    input  logic                         CLK_IN,
    input  logic                         RST_IN,
    input  logic [P_REQ*P_ADR_WIDTH-1:0] REQ_ADR_IN,
    input  logic [P_REQ-1:0]             REQ_WR_IN,
    input  logic [P_REQ-1:0]             REQ_RD_IN,
    input  logic [P_REQ*P_DAT_WIDTH-1:0] REQ_DIN_IN,
    output logic [P_DAT_WIDTH-1:0]       REQ_DOUT_OUT,
    output logic [P_REQ-1:0]             REQ_VLD_OUT,
    output logic [P_REQ-1:0]             REQ_RDY_OUT,
    output logic [P_ADR_WIDTH-1:0]       SLV_ADR_OUT,
    output logic                         SLV_WR_OUT,
    output logic                         SLV_RD_OUT,
    output logic [P_DAT_WIDTH-1:0]       SLV_DIN_OUT,
    input  logic [P_DAT_WIDTH-1:0]       SLV_DOUT_IN,
    input  logic                         SLV_VLD_IN,
    output logic                         ERR_OUT
);

    localparam int                        IW       = (P_REQ > 1) ? $clog2(P_REQ) : 1;
    localparam logic [7:0]                TO_CNT   = 8'(P_TIMEOUT);
    localparam logic [P_DAT_WIDTH+31:0]   ERR_EXT  = {{P_DAT_WIDTH{1'b0}}, ERR_DATA};
    localparam logic [P_DAT_WIDTH-1:0]    ERR_WORD = ERR_EXT[P_DAT_WIDTH-1:0];
    localparam logic [P_REQ-1:0]          ONE      = P_REQ'(1);

    lb_state_t               state, state_nxt;
    logic [IW-1:0]           ptr_q;
    logic [IW-1:0]           gnt_q;
    logic [P_ADR_WIDTH-1:0]  adr_q;
    logic [P_DAT_WIDTH-1:0]  din_q;
    logic [P_DAT_WIDTH-1:0]  dout_q;
    logic                    wr_q;
    logic                    err_q;
    logic [7:0]              cnt_q;
    logic [7:0]              cnt_inc;
    logic                    timeout_hit;

    logic [P_REQ-1:0]        arb_gnt;
    logic [IW-1:0]           arb_idx;
    logic                    arb_any;
    logic [P_ADR_WIDTH-1:0]  sel_adr;
    logic [P_DAT_WIDTH-1:0]  sel_din;
    logic                    sel_wr;
    logic [P_REQ-1:0]        gnt_oh;

    prt_dp_lib_rr_arb #(
        .P_REQ   (P_REQ),
        .P_IDX_W (IW)
    ) u_rr_arb (
        .req     (REQ_WR_IN | REQ_RD_IN),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Select the winning requester's address, data and operation (write beats read)
    always_comb begin
        sel_adr = '0;
        sel_din = '0;
        sel_wr  = 1'b0;
        for (int n = 0; n < P_REQ; n++) begin
            if (arb_gnt[n]) begin
                sel_adr = REQ_ADR_IN[n*P_ADR_WIDTH +: P_ADR_WIDTH];
                sel_din = REQ_DIN_IN[n*P_DAT_WIDTH +: P_DAT_WIDTH];
                sel_wr  = REQ_WR_IN[n];
            end
        end
    end

    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TO_CNT);

    // State register
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: arbitration only in IDLE, one access in flight
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = wr_q ? ST_IDLE : ST_RWAIT;
            ST_RWAIT: if (SLV_VLD_IN || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant capture, timeout counting and read-data capture
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            ptr_q  <= IW'(P_REQ - 1);
            gnt_q  <= '0;
            adr_q  <= '0;
            din_q  <= '0;
            dout_q <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q <= arb_idx;
                        ptr_q <= arb_idx;
                        adr_q <= sel_adr;
                        din_q <= sel_din;
                        wr_q  <= sel_wr;
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_RWAIT: begin
                    if (SLV_VLD_IN) begin
                        dout_q <= SLV_DOUT_IN;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            dout_q <= ERR_WORD;
                            err_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt_oh       = ONE << gnt_q;
    assign SLV_WR_OUT   = (state == ST_ISSUE) && wr_q;
    assign SLV_RD_OUT   = (state == ST_ISSUE) && !wr_q;
    assign SLV_ADR_OUT  = adr_q;
    assign SLV_DIN_OUT  = din_q;
    assign REQ_DOUT_OUT = dout_q;
    assign ERR_OUT      = err_q;
    assign REQ_VLD_OUT  = (state == ST_RESP) ? gnt_oh : '0;
    assign REQ_RDY_OUT  = (SLV_WR_OUT || state == ST_RESP) ? gnt_oh : '0;

endmodule

// File: tb/tb_prt_dp_pm_lb_arb.sv
// tb/tb_prt_dp_pm_lb_arb.sv - self-checking bench for prt_dp_pm_lb_arb
module tb_prt_dp_pm_lb_arb;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 15;
    localparam logic [31:0] DEAD = 32'hdeadcafe;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*AW-1:0] req_adr;
    logic [N-1:0]    req_wr;
    logic [N-1:0]    req_rd;
    logic [N*DW-1:0] req_din;
    logic [DW-1:0]   req_dout;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy;
    logic [AW-1:0]   slv_adr;
    logic            slv_wr;
    logic            slv_rd;
    logic [DW-1:0]   slv_din;
    logic [DW-1:0]   slv_dout;
    logic            slv_vld;
    logic            err;

    int checks   = 0;
    int failures = 0;
    int rr_model = N - 1;

    always #5 clk = ~clk;

    prt_dp_pm_lb_arb #(
        .P_REQ(N), .P_ADR_WIDTH(AW), .P_DAT_WIDTH(DW), .P_TIMEOUT(TO)
    ) dut (
        .CLK_IN(clk), .RST_IN(rst_n),
        .REQ_ADR_IN(req_adr), .REQ_WR_IN(req_wr), .REQ_RD_IN(req_rd), .REQ_DIN_IN(req_din),
        .REQ_DOUT_OUT(req_dout), .REQ_VLD_OUT(req_vld), .REQ_RDY_OUT(req_rdy),
        .SLV_ADR_OUT(slv_adr), .SLV_WR_OUT(slv_wr), .SLV_RD_OUT(slv_rd), .SLV_DIN_OUT(slv_din),
        .SLV_DOUT_IN(slv_dout), .SLV_VLD_IN(slv_vld), .ERR_OUT(err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] pend, input int ptr);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (pend[k]) return k;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = (r == -1) ? i : -2;
        end
        return r;
    endfunction

    task automatic set_req(input int n, input bit wr, input bit rd,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[n]          = wr;
        req_rd[n]          = rd;
        req_adr[n*AW +: AW] = a;
        req_din[n*DW +: DW] = d;
    endtask

    task automatic idle_cycle;
        step;
        checks++;
        if (slv_wr !== 1'b0 || slv_rd !== 1'b0 || req_rdy !== '0 || req_vld !== '0 || err !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet: wr=%b rd=%b rdy=%b vld=%b err=%b, want all 0", slv_wr, slv_rd, req_rdy, req_vld, err);
        end
    endtask

    // Serve the transaction the model says wins next; lat = slave answer delay after strobe, 0 = never
    task automatic serve(input bit keep, input int lat, input logic [DW-1:0] sdata, output int got);
        int            w;
        bit            is_wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [N-1:0]  oh;
        int            resp_c;
        int            exp_c;
        got = -1;
        w = pick(req_wr | req_rd, rr_model);
        if (w < 0) begin
            checks++; failures++;
            $display("FAIL serve_setup: no pending request");
            return;
        end
        is_wr = req_wr[w];
        ea    = req_adr[w*AW +: AW];
        ed    = req_din[w*DW +: DW];
        oh    = N'(1) << w;
        step;
        checks++;
        if (slv_wr !== is_wr || slv_rd !== !is_wr) begin
            failures++;
            $display("FAIL strobe: wr=%b rd=%b, want wr=%b rd=%b", slv_wr, slv_rd, is_wr, !is_wr);
        end
        checks++;
        if (slv_adr !== ea) begin
            failures++;
            $display("FAIL slv_adr: got %h want %h", slv_adr, ea);
        end
        rr_model = w;
        if (is_wr) begin
            got = oh_idx(req_rdy);
            checks++;
            if (slv_din !== ed) begin
                failures++;
                $display("FAIL slv_din: got %h want %h", slv_din, ed);
            end
            checks++;
            if (req_rdy !== oh || req_vld !== '0) begin
                failures++;
                $display("FAIL wr_ack: rdy=%b vld=%b, want rdy=%b vld=0", req_rdy, req_vld, oh);
            end
            if (!keep) begin req_wr[w] = 1'b0; req_rd[w] = 1'b0; end
            return;
        end
        checks++;
        if (req_rdy !== '0) begin
            failures++;
            $display("FAIL rd_issue_rdy: got %b want 0", req_rdy);
        end
        // spurious valid while still issuing must be ignored
        slv_vld  = 1'($urandom_range(0, 1));
        slv_dout = $urandom;
        exp_c  = (lat != 0) ? lat + 2 : TO + 2;
        resp_c = 0;
        for (int c = 2; c <= TO + 4 && resp_c == 0; c++) begin
            step;
            if (req_vld !== '0) begin
                resp_c = c;
            end else begin
                checks++;
                if (req_rdy !== '0 || err !== 1'b0 || slv_rd !== 1'b0 || slv_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL rwait_quiet: cyc=%0d rdy=%b err=%b rd=%b wr=%b, want all 0", c, req_rdy, err, slv_rd, slv_wr);
                end
            end
            slv_vld  = (lat != 0 && c == lat + 1);
            slv_dout = slv_vld ? sdata : $urandom;
        end
        slv_vld = 1'b0;
        checks++;
        if (resp_c !== exp_c) begin
            failures++;
            $display("FAIL resp_cycle: got %0d want %0d", resp_c, exp_c);
        end
        if (resp_c != 0) begin
            got = oh_idx(req_rdy);
            checks++;
            if (req_vld !== oh || req_rdy !== oh) begin
                failures++;
                $display("FAIL rd_ack: vld=%b rdy=%b, want %b", req_vld, req_rdy, oh);
            end
            checks++;
            if (req_dout !== ((lat != 0) ? sdata : DEAD)) begin
                failures++;
                $display("FAIL rd_data: got %h want %h", req_dout, (lat != 0) ? sdata : DEAD);
            end
            checks++;
            if (err !== (lat == 0)) begin
                failures++;
                $display("FAIL err_pulse: got %b want %b", err, lat == 0);
            end
        end
        if (!keep) begin req_wr[w] = 1'b0; req_rd[w] = 1'b0; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_wr = '0; req_rd = '0; req_adr = '0; req_din = '0;
        slv_vld = 1'b0; slv_dout = '0;
        step; step;
        checks++;
        if (req_dout !== '0 || req_vld !== '0 || req_rdy !== '0 || slv_adr !== '0 ||
            slv_wr !== 1'b0 || slv_rd !== 1'b0 || slv_din !== '0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: dout=%h vld=%b rdy=%b adr=%h wr=%b rd=%b din=%h err=%b, want all 0",
                     req_dout, req_vld, req_rdy, slv_adr, slv_wr, slv_rd, slv_din, err);
        end
        rst_n = 1'b1;
        rr_model = N - 1;
        idle_cycle;
    endtask

    task automatic test_write;
        int got;
        set_req(0, 1'b1, 1'b0, 4'd6, 32'h01);
        serve(1'b0, 0, '0, got);
        checks++;
        if (got !== 0) begin failures++; $display("FAIL write_grant: got %0d want 0", got); end
        idle_cycle;
    endtask

    task automatic test_read;
        int got;
        set_req(1, 1'b0, 1'b1, 4'd0, 32'h0);
        serve(1'b0, 1, 32'h12340100, got);
        checks++;
        if (got !== 1) begin failures++; $display("FAIL read_grant: got %0d want 1", got); end
        idle_cycle;
    endtask

    task automatic test_back_to_back;
        int got;
        set_req(0, 1'b1, 1'b0, 4'($urandom), $urandom);
        set_req(1, 1'b1, 1'b0, 4'($urandom), $urandom);
        for (int g = 0; g < 8; g++) begin
            serve(1'b1, 0, '0, got);
            checks++;
            if (got !== g % N) begin failures++; $display("FAIL fair_order: grant %0d got %0d want %0d", g, got, g % N); end
            if (g == 7) begin req_wr = '0; req_rd = '0; end
            idle_cycle;
        end
    endtask

    task automatic test_timeout;
        int got;
        set_req(0, 1'b0, 1'b1, 4'd3, '0);
        serve(1'b0, 0, '0, got);
        idle_cycle;
        set_req(1, 1'b1, 1'b0, 4'd9, 32'hcafe0001);
        serve(1'b0, 0, '0, got);
        checks++;
        if (got !== 1) begin failures++; $display("FAIL after_timeout_grant: got %0d want 1", got); end
        idle_cycle;
    endtask

    task automatic test_reset_mid;
        int got;
        set_req(0, 1'b0, 1'b1, 4'd5, '0);
        step; step; step;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (req_dout !== '0 || req_vld !== '0 || req_rdy !== '0 || slv_adr !== '0 ||
            slv_wr !== 1'b0 || slv_rd !== 1'b0 || slv_din !== '0 || err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: dout=%h vld=%b rdy=%b adr=%h wr=%b rd=%b din=%h err=%b, want all 0",
                     req_dout, req_vld, req_rdy, slv_adr, slv_wr, slv_rd, slv_din, err);
        end
        req_rd = '0;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (req_vld !== '0 || req_rdy !== '0) begin
                failures++;
                $display("FAIL reset_abort: vld=%b rdy=%b, want 0", req_vld, req_rdy);
            end
        end
        rst_n = 1'b1;
        rr_model = N - 1;
        set_req(0, 1'b1, 1'b0, 4'd1, 32'h11);
        set_req(1, 1'b1, 1'b0, 4'd2, 32'h22);
        serve(1'b0, 0, '0, got);
        checks++;
        if (got !== 0) begin failures++; $display("FAIL post_reset_grant: got %0d want 0", got); end
        idle_cycle;
        serve(1'b0, 0, '0, got);
        idle_cycle;
    endtask

    task automatic test_both_ops;
        int got;
        set_req(0, 1'b1, 1'b1, 4'd7, 32'h5a5a5a5a);
        serve(1'b0, 0, '0, got);
        checks++;
        if (got !== 0) begin failures++; $display("FAIL both_grant: got %0d want 0", got); end
        idle_cycle;
        idle_cycle;
    endtask

    task automatic test_random;
        int got;
        int lat;
        for (int it = 0; it < 25; it++) begin
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 2))
                        0: set_req(n, 1'b1, 1'b0, 4'($urandom), $urandom);
                        1: set_req(n, 1'b0, 1'b1, 4'($urandom), $urandom);
                        default: set_req(n, 1'b1, 1'b1, 4'($urandom), $urandom);
                    endcase
                end
            end
            while ((req_wr | req_rd) != '0) begin
                lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
                serve(1'b0, lat, $urandom, got);
                idle_cycle;
            end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        test_both_ops;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prt_dp_pm_lb_arb.md
Name: prt_dp_pm_lb_arb

Overview:
- Local-bus arbiter sharing one policy-maker peripheral slave (PIO, timer, etc.) between P_REQ bus masters, e.g. the PM CPU and a hardware sequencer.
- Round-robin grant; exactly one slave access in flight.
- Guarantees a single rd strobe per read, because slaves have clear-on-read registers such as the PIO event registers.
- Read timeout returns an error word so a dead slave never hangs a master.

Parameters:
P_REQ, 2, number of requesters (2..8)
P_ADR_WIDTH, 4, local bus address width
P_DAT_WIDTH, 32, local bus data width
P_TIMEOUT, 15, max cycles from slave rd strobe to SLV_VLD_IN before abort (1..255)

Ports:
CLK_IN  in  1  clock
RST_IN  in  1  asynchronous, active-low reset
REQ_ADR_IN  in  P_REQ*P_ADR_WIDTH  per-requester address, requester n at [n*P_ADR_WIDTH +: P_ADR_WIDTH]
REQ_WR_IN  in  P_REQ  write request, level, held until REQ_RDY_OUT
REQ_RD_IN  in  P_REQ  read request, level, held until REQ_RDY_OUT
REQ_DIN_IN  in  P_REQ*P_DAT_WIDTH  per-requester write data
REQ_DOUT_OUT  out  P_DAT_WIDTH  read data, shared, qualified by REQ_VLD_OUT
REQ_VLD_OUT  out  P_REQ  one-cycle read-data-valid to the owning requester
REQ_RDY_OUT  out  P_REQ  one-cycle transaction-complete acknowledge
SLV_ADR_OUT  out  P_ADR_WIDTH  slave address
SLV_WR_OUT  out  1  slave write strobe, one cycle
SLV_RD_OUT  out  1  slave read strobe, one cycle
SLV_DIN_OUT  out  P_DAT_WIDTH  slave write data
SLV_DOUT_IN  in  P_DAT_WIDTH  slave read data
SLV_VLD_IN  in  1  slave read valid
ERR_OUT  out  1  one-cycle pulse on read timeout

Behaviour:
- Reset (RST_IN=0, async): state IDLE; all outputs 0; rr pointer = P_REQ-1, so requester 0 wins first; timeout counter 0. Reset mid-transaction aborts it with no RDY/VLD. Any strobe already at the slave is not recalled.
- Request: REQ_WR_IN[n] | REQ_RD_IN[n]. Both set means a write; RDY acknowledges both.
- FSM states: IDLE, ISSUE, RWAIT, RESP.
- IDLE: if any request, pick the first requester after the rr pointer (modulo P_REQ). Register grant index, adr, din and op. Update the pointer to the winner. Go to ISSUE.
- ISSUE, one cycle: drive SLV_ADR_OUT/SLV_DIN_OUT from registers.
  - Write: SLV_WR_OUT=1 and REQ_RDY_OUT[g]=1, then IDLE.
  - Read: SLV_RD_OUT=1, clear counter, go to RWAIT.
- SLV_ADR_OUT/SLV_DIN_OUT hold their value after ISSUE until the next grant.
- RWAIT:
  - If SLV_VLD_IN, register SLV_DOUT_IN and go to RESP.
  - Else counter+1. When counter == P_TIMEOUT, register 32'hdeadcafe (truncated/zero-extended to P_DAT_WIDTH), set ERR_OUT=1 for one cycle, go to RESP.
- RESP, one cycle: REQ_VLD_OUT[g]=1, REQ_RDY_OUT[g]=1, REQ_DOUT_OUT = registered data, then IDLE. REQ_DOUT_OUT holds its value until the next RESP.
- Latency, request seen in IDLE at cycle 0:
  - Write: slave strobe and RDY in cycle 1.
  - Read, slave answering one cycle after the strobe: strobe cycle 1, SLV_VLD_IN cycle 2, VLD+RDY cycle 3.
- Throughput: 1 write per 2 cycles; 1 read per 4 cycles minimum.
- SLV_VLD_IN outside RWAIT is ignored.
- A requester that drops its request after grant: the access still completes and its RDY/VLD still pulse.
- Arbitration is sampled only in IDLE; new requests during a transaction wait.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,..,P_REQ-1,0…
- At most one bit of REQ_RDY_OUT and REQ_VLD_OUT set per cycle. SLV_WR_OUT and SLV_RD_OUT never both set.

Decomposition:
- Package prt_dp_pm_lb_arb_pkg: FSM state enum (IDLE, ISSUE, RWAIT, RESP) and the error data constant 32'hdeadcafe.
- Sub-module prt_dp_lib_rr_arb: combinational round-robin grant.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index, any-request.
  - Reusable by other PM arbiters.

Test Plan:
- Req0 write adr 6 din 0x01 alone -> cycle 1: SLV_WR_OUT=1, SLV_ADR_OUT=6, SLV_DIN_OUT=0x01, REQ_RDY_OUT=2'b01; no VLD.
- Req1 read adr 0, slave returns 0x12340100 one cycle after strobe -> exactly one SLV_RD_OUT pulse; cycle 3: REQ_VLD_OUT=2'b10, REQ_DOUT_OUT=0x12340100, RDY=2'b10.
- Both requesters hold writes continuously for 8 grants -> grant order 0,1,0,1,0,1,0,1, one SLV_WR_OUT every 2 cycles.
- Read with slave never asserting vld, P_TIMEOUT=15 -> 15 cycles in RWAIT, then ERR_OUT pulse, REQ_DOUT_OUT=0xdeadcafe with VLD+RDY; the next request is served normally.
- RST_IN low during RWAIT -> all outputs 0 immediately, no VLD/RDY for the aborted read; after release req0 wins first.
- REQ_WR_IN and REQ_RD_IN both set on req0 -> single SLV_WR_OUT, no SLV_RD_OUT, RDY=2'b01, VLD stays 0.
